doa_sequencer: RTL and testbench

DOA_SEQUENCER -- requirements
Module: doa_sequencer

---
 rtl/doa_pkg.sv | 34 +++
 rtl/stage_watchdog.sv | 26 ++
 rtl/doa_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_doa_sequencer.sv | 528 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/doa_pkg.sv
// Shared types and constants for the DOA sequencer slice:
// FSM state enum, fixed field widths and the published result bundle.
package doa_pkg;

  localparam int NUM_BEAMS = 13;
  localparam int NUM_MICS  = 4;
  localparam int BIN_W     = 10;
  localparam int DOA_W     = 8;
  localparam int BEAM_W    = 4;
  localparam int SEQ_MAX_W = 16;
  localparam int OVR_W     = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_FFT,
    S_DETECT,
    S_BEAM
  } state_t;

  // seq is carried at its widest size; the top narrows it to SEQ_W
  typedef struct packed {
    logic [DOA_W-1:0]     doa;
    logic [BIN_W-1:0]     bin;
    logic [BEAM_W-1:0]    beam;
    logic [SEQ_MAX_W-1:0] seq;
  } result_t;

  // states that wait on an external done pulse under the watchdog
  function automatic logic in_stage(state_t s);
    return (s == S_FFT) || (s == S_DETECT) || (s == S_BEAM);
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage watchdog: counter cleared on stage entry, counts while run.
// Ports: clk, reset, clear, run in; expired out (limit reached while run).
module stage_watchdog #(
  parameter int LIMIT = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  assign expired = run && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear)
      cnt <= '0;
    else if (run && !expired)
      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/doa_sequencer.sv
// DOA frame sequencer: FFT -> peak detect -> beam weighting, then publish.
// Ports: stage start/done handshakes, result regs + ack, busy, error status.
module doa_sequencer
  import doa_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int SEQ_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             frame_ready,
  output logic             fft_start,
  input  logic             fft_done,
  output logic             detect_start,
  input  logic             detect_done,
  input  logic [9:0]       maxbin_in,
  output logic             wb_trigger,
  output logic [9:0]       wb_maxbin,
  input  logic             wb_done,
  input  logic [7:0]       wb_doa,
  input  logic [3:0]       wb_bnum,
  output logic             result_valid,
  output logic [7:0]       result_doa,
  output logic [9:0]       result_bin,
  output logic [3:0]       result_beam,
  output logic [SEQ_W-1:0] result_seq,
  input  logic             result_ack,
  output logic             busy,
  output logic [7:0]       overrun_cnt,
  output logic             timeout_err,
  input  logic             err_clr
);

  state_t state, state_n;

  logic fft_go, det_go, wb_go;
  logic latch_bin, publish, tmo;
  logic expired, wd_clear, wd_run;
  logic ovr_inc;

  logic [SEQ_W-1:0] seq_q;
  result_t          res_q;

  assign wd_run   = in_stage(state);
  assign wd_clear = (state_n != state) && in_stage(state_n);

  stage_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wd (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .run    (wd_run),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  // a done pulse beats a watchdog expiry in the same cycle
  always_comb begin
    state_n   = state;
    fft_go    = 1'b0;
    det_go    = 1'b0;
    wb_go     = 1'b0;
    latch_bin = 1'b0;
    publish   = 1'b0;
    tmo       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable)
          state_n = S_WAIT_FRAME;
      end
      S_WAIT_FRAME: begin
        if (!enable) begin
          state_n = S_IDLE;
        end else if (frame_ready) begin
          state_n = S_FFT;
          fft_go  = 1'b1;
        end
      end
      S_FFT: begin
        if (fft_done) begin
          state_n = S_DETECT;
          det_go  = 1'b1;
        end else if (expired) begin
          tmo     = 1'b1;
          state_n = enable ? S_WAIT_FRAME : S_IDLE;
        end
      end
      S_DETECT: begin
        if (detect_done) begin
          latch_bin = 1'b1;
          if (maxbin_in == '0) begin
            state_n = enable ? S_WAIT_FRAME : S_IDLE;
          end else begin
            state_n = S_BEAM;
            wb_go   = 1'b1;
          end
        end else if (expired) begin
          tmo     = 1'b1;
          state_n = enable ? S_WAIT_FRAME : S_IDLE;
        end
      end
      S_BEAM: begin
        if (wb_done) begin
          publish = 1'b1;
          state_n = enable ? S_WAIT_FRAME : S_IDLE;
        end else if (expired) begin
          tmo     = 1'b1;
          state_n = enable ? S_WAIT_FRAME : S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fft_start    <= 1'b0;
      detect_start <= 1'b0;
      wb_trigger   <= 1'b0;
    end else begin
      fft_start    <= fft_go;
      detect_start <= det_go;
      wb_trigger   <= wb_go;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      wb_maxbin <= '0;
    else if (latch_bin)
      wb_maxbin <= maxbin_in;
  end

  always_ff @(posedge clk) begin
    if (reset)
      seq_q <= '0;
    else if (fft_go)
      seq_q <= seq_q + SEQ_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q        <= '0;
      result_valid <= 1'b0;
    end else if (publish) begin
      if (!result_valid || result_ack) begin
        res_q <= '{doa:  wb_doa,
                   bin:  wb_maxbin,
                   beam: wb_bnum,
                   seq:  SEQ_MAX_W'(seq_q)};
        result_valid <= 1'b1;
      end
    end else if (result_ack) begin
      result_valid <= 1'b0;
    end
  end

  assign ovr_inc = publish && result_valid && !result_ack;

  // a new event wins over a clear landing in the same cycle
  always_ff @(posedge clk) begin
    if (reset)
      overrun_cnt <= '0;
    else if (ovr_inc)
      overrun_cnt <= err_clr ? 8'd1 :
                     (overrun_cnt == 8'hFF) ? overrun_cnt :
                     overrun_cnt + 8'd1;
    else if (err_clr)
      overrun_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      timeout_err <= 1'b0;
    else if (tmo)
      timeout_err <= 1'b1;
    else if (err_clr)
      timeout_err <= 1'b0;
  end

  assign result_doa  = res_q.doa;
  assign result_bin  = res_q.bin;
  assign result_beam = res_q.beam;
  assign result_seq  = SEQ_W'(res_q.seq);
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_doa_sequencer.sv
// Bench for doa_sequencer: randomized frames against a result/overrun model.
// A second instance with a short watchdog limit covers the timeout path.
module tb_doa_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic frame_ready = 1'b0;
  logic fft_done = 1'b0;
  logic detect_done = 1'b0;
  logic wb_done = 1'b0;
  logic result_ack = 1'b0;
  logic err_clr = 1'b0;
  logic [9:0] maxbin_in = '0;
  logic [7:0] wb_doa = '0;
  logic [3:0] wb_bnum = '0;

  logic fft_start, detect_start, wb_trigger;
  logic [9:0] wb_maxbin;
  logic result_valid;
  logic [7:0] result_doa;
  logic [9:0] result_bin;
  logic [3:0] result_beam;
  logic [7:0] result_seq;
  logic busy;
  logic [7:0] overrun_cnt;
  logic timeout_err;

  logic w_fft_start, w_detect_start, w_wb_trigger;
  logic [9:0] w_wb_maxbin;
  logic w_result_valid;
  logic [7:0] w_result_doa;
  logic [9:0] w_result_bin;
  logic [3:0] w_result_beam;
  logic [7:0] w_result_seq;
  logic w_busy;
  logic [7:0] w_overrun_cnt;
  logic w_timeout_err;

  doa_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable),
    .frame_ready(frame_ready), .fft_start(fft_start),
    .fft_done(fft_done), .detect_start(detect_start),
    .detect_done(detect_done), .maxbin_in(maxbin_in),
    .wb_trigger(wb_trigger), .wb_maxbin(wb_maxbin),
    .wb_done(wb_done), .wb_doa(wb_doa), .wb_bnum(wb_bnum),
    .result_valid(result_valid), .result_doa(result_doa),
    .result_bin(result_bin), .result_beam(result_beam),
    .result_seq(result_seq), .result_ack(result_ack),
    .busy(busy), .overrun_cnt(overrun_cnt),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  doa_sequencer #(.TIMEOUT_CYCLES(16)) dut_wd (
    .clk(clk), .reset(reset), .enable(enable),
    .frame_ready(frame_ready), .fft_start(w_fft_start),
    .fft_done(fft_done), .detect_start(w_detect_start),
    .detect_done(detect_done), .maxbin_in(maxbin_in),
    .wb_trigger(w_wb_trigger), .wb_maxbin(w_wb_maxbin),
    .wb_done(wb_done), .wb_doa(wb_doa), .wb_bnum(wb_bnum),
    .result_valid(w_result_valid), .result_doa(w_result_doa),
    .result_bin(w_result_bin), .result_beam(w_result_beam),
    .result_seq(w_result_seq), .result_ack(result_ack),
    .busy(w_busy), .overrun_cnt(w_overrun_cnt),
    .timeout_err(w_timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model of the host-visible result state
  bit       m_valid;
  bit [7:0] m_doa;
  bit [9:0] m_bin;
  bit [3:0] m_beam;
  bit [7:0] m_seq;
  int       m_ovr;
  int       m_frames;

  // observations from the last run_frame
  logic o_fs, o_ds, o_wt;
  logic [9:0] o_wm, o_wm2;

  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      if (int'(fft_start) + int'(detect_start) + int'(wb_trigger) > 1) begin
        n_err++;
        $display("FAIL pulse_onehot: got %b%b%b expected at most one",
                 fft_start, detect_start, wb_trigger);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_valid = 0; m_doa = 0; m_bin = 0; m_beam = 0;
    m_seq = 0; m_ovr = 0; m_frames = 0;
  endtask

  task automatic model_publish(input bit [7:0] doa, input bit [9:0] bin,
                               input bit [3:0] bnum, input bit ack,
                               input bit clr);
    if (!m_valid || ack) begin
      m_valid = 1; m_doa = doa; m_bin = bin; m_beam = bnum;
      m_seq = 8'(m_frames);
      if (clr) m_ovr = 0;
    end else begin
      m_ovr = clr ? 1 : (m_ovr < 255 ? m_ovr + 1 : 255);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic host_ack();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    m_valid = 0;
  endtask

  task automatic host_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_ovr = 0;
  endtask

  // one full frame starting in WAIT_FRAME; d idle cycles before each done
  task automatic run_frame(input int d, input logic [9:0] bin,
                           input logic [7:0] doa, input logic [3:0] bnum,
                           input bit ack, input bit clr);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    o_fs = fft_start;
    m_frames++;
    repeat (d) tick();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    o_ds = detect_start;
    repeat (d) tick();
    maxbin_in = bin;
    detect_done = 1'b1;
    tick();
    detect_done = 1'b0;
    maxbin_in = 10'h3FF;
    o_wt = wb_trigger;
    o_wm = wb_maxbin;
    o_wm2 = wb_maxbin;
    if (bin != 0) begin
      repeat (d) tick();
      o_wm2 = wb_maxbin;
      wb_doa = doa;
      wb_bnum = bnum;
      wb_done = 1'b1;
      result_ack = ack;
      err_clr = clr;
      tick();
      wb_done = 1'b0;
      result_ack = 1'b0;
      err_clr = 1'b0;
      model_publish(doa, bin, bnum, ack, clr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({fft_start, detect_start, wb_trigger, wb_maxbin, result_valid,
         result_doa, result_bin, result_beam, result_seq, busy,
         overrun_cnt, timeout_err} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got valid=%b busy=%b ovr=%0d terr=%b expected all zero",
               result_valid, busy, overrun_cnt, timeout_err);
    end
    reset = 1'b0;
    model_reset();
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_basic();
    enable = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL wait_busy: got %b expected 1", busy);
    end
    run_frame(19, 10'd37, 8'hD3, 4'd3, 1'b0, 1'b0);
    n_cmp++;
    if ({o_fs, o_ds, o_wt} !== 3'b111) begin
      n_err++;
      $display("FAIL basic_pulses: got %b expected 111", {o_fs, o_ds, o_wt});
    end
    n_cmp++;
    if (o_wm !== 10'd37 || o_wm2 !== 10'd37) begin
      n_err++;
      $display("FAIL basic_wb_maxbin: got %0d/%0d expected 37", o_wm, o_wm2);
    end
    n_cmp++;
    if ({result_valid, result_doa, result_bin, result_beam, result_seq, busy}
        !== {1'b1, 8'hD3, 10'd37, 4'd3, 8'd1, 1'b1}) begin
      n_err++;
      $display("FAIL basic_result: got v=%b doa=%0d bin=%0d beam=%0d seq=%0d busy=%b expected 1,-45,37,3,1,1",
               result_valid, $signed(result_doa), result_bin, result_beam,
               result_seq, busy);
    end
  endtask

  task automatic test_no_tone();
    run_frame(3, 10'd0, 8'h00, 4'd0, 1'b0, 1'b0);
    n_cmp++;
    if (o_wt !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL notone_trig: got wt=%b busy=%b expected 0,1", o_wt, busy);
    end
    n_cmp++;
    if ({result_valid, result_doa, result_bin, result_beam, result_seq}
        !== {m_valid, m_doa, m_bin, m_beam, m_seq}) begin
      n_err++;
      $display("FAIL notone_result: got v=%b bin=%0d seq=%0d expected v=%b bin=%0d seq=%0d",
               result_valid, result_bin, result_seq, m_valid, m_bin, m_seq);
    end
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    m_frames++;
    n_cmp++;
    if (fft_start !== 1'b1) begin
      n_err++;
      $display("FAIL notone_wait_frame: got fft_start=%b expected 1", fft_start);
    end
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    maxbin_in = 10'd0;
    detect_done = 1'b1;
    tick();
    detect_done = 1'b0;
  endtask

  task automatic test_overrun();
    logic [7:0] a_doa;
    logic [9:0] a_bin;
    host_ack();
    host_clr();
    for (int i = 0; i < 6; i++) begin
      logic [7:0] doa;
      logic [9:0] bin;
      logic [3:0] bn;
      bit ack, clr;
      doa = 8'(int'($urandom_range(0, 180)) - 90);
      bin = 10'($urandom_range(1, 1023));
      bn = 4'($urandom_range(0, 12));
      ack = (i == 2 || i == 5);
      clr = (i == 5);
      if (i == 5) clr = 1'b0;
      if (i == 4) clr = 1'b1;
      run_frame(2, bin, doa, bn, ack, clr);
      if (i == 0) begin
        a_doa = doa;
        a_bin = bin;
      end
      if (i == 1) begin
        n_cmp++;
        if (result_doa !== a_doa || result_bin !== a_bin ||
            overrun_cnt !== 8'd1) begin
          n_err++;
          $display("FAIL overrun_retain: got doa=%h bin=%0d ovr=%0d expected doa=%h bin=%0d ovr=1",
                   result_doa, result_bin, overrun_cnt, a_doa, a_bin);
        end
      end
      if (i == 2) begin
        n_cmp++;
        if (result_doa !== doa || result_bin !== bin ||
            overrun_cnt !== 8'd1 || result_valid !== 1'b1) begin
          n_err++;
          $display("FAIL overrun_ack_load: got doa=%h bin=%0d ovr=%0d v=%b expected doa=%h bin=%0d ovr=1 v=1",
                   result_doa, result_bin, overrun_cnt, result_valid, doa, bin);
        end
      end
      if (i == 4) begin
        n_cmp++;
        if (overrun_cnt !== 8'd1) begin
          n_err++;
          $display("FAIL overrun_clr_race: got %0d expected 1", overrun_cnt);
        end
      end
      n_cmp++;
      if ({result_valid, result_doa, result_bin, result_beam, result_seq,
           overrun_cnt} !== {m_valid, m_doa, m_bin, m_beam, m_seq, 8'(m_ovr)}) begin
        n_err++;
        $display("FAIL overrun_model_%0d: got bin=%0d seq=%0d ovr=%0d expected bin=%0d seq=%0d ovr=%0d",
                 i, result_bin, result_seq, overrun_cnt, m_bin, m_seq, m_ovr);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    enable = 1'b1;
    tick();
    for (int pass = 0; pass < 2; pass++) begin
      frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
      n_cmp++;
      if (w_fft_start !== 1'b1) begin
        n_err++;
        $display("FAIL tmo_fft_start_%0d: got %b expected 1", pass, w_fft_start);
      end
      repeat (15) tick();
      n_cmp++;
      if (w_busy !== 1'b1 || (pass == 0 && w_timeout_err !== 1'b0)) begin
        n_err++;
        $display("FAIL tmo_early_%0d: got terr=%b busy=%b expected busy=1",
                 pass, w_timeout_err, w_busy);
      end
      err_clr = (pass == 1);
      tick();
      err_clr = 1'b0;
      n_cmp++;
      if (w_timeout_err !== 1'b1 || w_result_valid !== 1'b0) begin
        n_err++;
        $display("FAIL tmo_set_%0d: got terr=%b v=%b expected 1,0",
                 pass, w_timeout_err, w_result_valid);
      end
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++;
    if (w_timeout_err !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_clear: got %b expected 0", w_timeout_err);
    end
    do_reset();
  endtask

  task automatic test_enable_drop();
    enable = 1'b1;
    tick();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    m_frames++;
    repeat (3) tick();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    enable = 1'b0;
    repeat (3) tick();
    maxbin_in = 10'd100;
    detect_done = 1'b1;
    tick();
    detect_done = 1'b0;
    n_cmp++;
    if (wb_trigger !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL drop_beam: got wt=%b busy=%b expected 1,1", wb_trigger, busy);
    end
    repeat (3) tick();
    wb_doa = 8'd60;
    wb_bnum = 4'd12;
    wb_done = 1'b1;
    tick();
    wb_done = 1'b0;
    model_publish(8'd60, 10'd100, 4'd12, 1'b0, 1'b0);
    n_cmp++;
    if ({result_valid, result_doa, result_bin, result_beam, result_seq, busy}
        !== {m_valid, m_doa, m_bin, m_beam, m_seq, 1'b0}) begin
      n_err++;
      $display("FAIL drop_publish: got v=%b bin=%0d seq=%0d busy=%b expected v=1 bin=100 seq=%0d busy=0",
               result_valid, result_bin, result_seq, busy, m_seq);
    end
    enable = 1'b1;
    tick();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    maxbin_in = 10'd200;
    detect_done = 1'b1;
    tick();
    detect_done = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    n_cmp++;
    if ({fft_start, detect_start, wb_trigger, wb_maxbin, result_valid,
         result_doa, result_bin, result_beam, result_seq, busy,
         overrun_cnt, timeout_err} !== '0) begin
      n_err++;
      $display("FAIL beam_reset: got wbm=%0d v=%b busy=%b seq=%0d expected all zero",
               wb_maxbin, result_valid, busy, result_seq);
    end
    wb_doa = 8'd5;
    wb_bnum = 4'd1;
    wb_done = 1'b1;
    tick();
    wb_done = 1'b0;
    n_cmp++;
    if (result_valid !== 1'b0 || wb_trigger !== 1'b0) begin
      n_err++;
      $display("FAIL late_wb_done: got v=%b wt=%b expected 0,0", result_valid, wb_trigger);
    end
  endtask

  task automatic test_seq_wrap();
    logic [7:0] prev;
    do_reset();
    enable = 1'b1;
    tick();
    prev = 8'hAA;
    for (int i = 1; i <= 256; i++) begin
      run_frame(1, 10'($urandom_range(1, 1023)), 8'd0, 4'd0, 1'b1, 1'b0);
      n_cmp++;
      if (result_seq !== m_seq || result_valid !== 1'b1) begin
        n_err++;
        $display("FAIL seq_%0d: got %0d expected %0d", i, result_seq, m_seq);
      end
      if (i == 256) begin
        n_cmp++;
        if (prev !== 8'd255 || result_seq !== 8'd0) begin
          n_err++;
          $display("FAIL seq_wrap: got %0d->%0d expected 255->0", prev, result_seq);
        end
      end
      prev = result_seq;
    end
  endtask

  task automatic test_saturate();
    do_reset();
    enable = 1'b1;
    tick();
    for (int i = 0; i < 258; i++)
      run_frame(1, 10'd9, 8'd1, 4'd2, 1'b0, 1'b0);
    n_cmp++;
    if (overrun_cnt !== 8'(m_ovr) || overrun_cnt !== 8'd255) begin
      n_err++;
      $display("FAIL ovr_saturate: got %0d expected %0d", overrun_cnt, m_ovr);
    end
    host_clr();
    n_cmp++;
    if (overrun_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL ovr_clear: got %0d expected 0", overrun_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [9:0] bin;
      bin = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      run_frame(int'($urandom_range(1, 6)), bin,
                8'(int'($urandom_range(0, 180)) - 90),
                4'($urandom_range(0, 12)),
                bit'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0));
      n_cmp++;
      if ({result_valid, result_doa, result_bin, result_beam, result_seq,
           overrun_cnt, timeout_err}
          !== {m_valid, m_doa, m_bin, m_beam, m_seq, 8'(m_ovr), 1'b0}) begin
        n_err++;
        $display("FAIL random_%0d: got v=%b doa=%h bin=%0d beam=%0d seq=%0d ovr=%0d expected v=%b doa=%h bin=%0d beam=%0d seq=%0d ovr=%0d",
                 i, result_valid, result_doa, result_bin, result_beam,
                 result_seq, overrun_cnt, m_valid, m_doa, m_bin, m_beam,
                 m_seq, m_ovr);
      end
      if ($urandom_range(0, 3) == 0) begin
        host_ack();
        n_cmp++;
        if (result_valid !== 1'b0) begin
          n_err++;
          $display("FAIL random_ack_%0d: got %b expected 0", i, result_valid);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_no_tone();
    test_overrun();
    test_timeout();
    test_enable_drop();
    test_seq_wrap();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
